// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parameterised FIFO pipeline stage with flush and saturating discard count
// Registered-only handshakes: in_ready_o and out_valid_o are derived from the held count alone.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic [15:0]      flush_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [15:0]      flush_cnt;
  logic             push;
  logic             pop;
  logic [CW-1:0]    discard;
  logic [16:0]      flush_sum;

  assign in_ready_o  = (count != FULL);
  assign out_valid_o = (count != '0);
  assign out_data_o  = out_valid_o ? mem[head] : '0;
  assign count_o     = count;
  assign flush_cnt_o = flush_cnt;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  // A pop in the flush cycle still delivers the head, so it is not counted as discarded.
  assign discard   = count - CW'(pop);
  assign flush_sum = {1'b0, flush_cnt} + 17'(discard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flush_cnt <= '0;
    end else if (flush_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end else begin
      if (push) tail <= (tail == LAST) ? '0 : tail + PW'(1);
      if (pop)  head <= (head == LAST) ? '0 : head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_data_i;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf (DEPTH=2 and DEPTH=3)
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_count;
  logic [15:0] a_flush_cnt;

  logic       b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_count;
  logic [15:0] b_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count), .flush_cnt_o(a_flush_cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count), .flush_cnt_o(b_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", a_count); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", a_out_data); end
    checks++; if (a_flush_cnt !== 16'h0) begin errors++; $display("FAIL reset_flush_cnt got %h want 0000", a_flush_cnt); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    a_in_valid = 1'b1; a_in_data = 8'hA1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_data !== 8'hA1) begin errors++; $display("FAIL single_data got %h want a1", a_out_data); end
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_count); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL single_drain_data got %h want 00", a_out_data); end
  endtask

  task automatic test_fill;
    a_in_valid = 1'b1; a_in_data = 8'hA1; a_out_ready = 1'b0;
    tick();
    a_in_data = 8'hB2;
    tick();
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", a_in_ready); end
    a_in_data = 8'hC3;
    tick();
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL fill_c3_count got %0d want 2", a_count); end
    checks++; if (a_out_data !== 8'hA1) begin errors++; $display("FAIL fill_head got %h want a1", a_out_data); end
    // Pop while full with an offer pending: offer is refused, ready rises only afterwards.
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL fill_pop1_count got %0d want 1", a_count); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_rise got %b want 1", a_in_ready); end
    checks++; if (a_out_data !== 8'hB2) begin errors++; $display("FAIL fill_second got %h want b2", a_out_data); end
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL fill_empty_data got %h want 00", a_out_data); end
  endtask

  task automatic test_back_to_back;
    a_in_valid = 1'b1; a_in_data = 8'h01; a_out_ready = 1'b0;
    tick();
    a_out_ready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      a_in_data = 8'(i);
      checks++; if (a_out_data !== 8'(i - 1)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, a_out_data, 8'(i - 1)); end
      tick();
      checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, a_count); end
    end
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 8'h10) begin errors++; $display("FAIL stream_last got %h want 10", a_out_data); end
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL stream_drain got %0d want 0", a_count); end
  endtask

  task automatic test_flush;
    a_in_valid = 1'b1; a_in_data = 8'h11;
    tick();
    a_in_data = 8'h22;
    tick();
    a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 8'h33;
    checks++; if (a_out_data !== 8'h11) begin errors++; $display("FAIL flush_head got %h want 11", a_out_data); end
    tick();
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d want 0", a_count); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
    checks++; if (a_flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt1 got %0d want 1", a_flush_cnt); end
    a_flush = 1'b0; a_out_ready = 1'b0; a_in_data = 8'h44;
    tick();
    a_flush = 1'b1; a_in_valid = 1'b0;
    tick();
    a_flush = 1'b0;
    checks++; if (a_flush_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt2 got %0d want 2", a_flush_cnt); end
    a_in_valid = 1'b1; a_in_data = 8'h55;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 8'h55) begin errors++; $display("FAIL flush_after got %h want 55", a_out_data); end
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL flush_after_count got %0d want 1", a_count); end
  endtask

  task automatic test_wrap;
    int ops[14]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
    int cnts[14] = '{1, 2, 3, 2, 1, 2, 3, 2, 1, 0, 1, 2, 1, 0};
    logic [7:0] next_in  = 8'h10;
    logic [7:0] next_out = 8'h10;
    for (int i = 0; i < 14; i++) begin
      if (ops[i] == 1) begin
        b_in_valid = 1'b1; b_out_ready = 1'b0; b_in_data = next_in;
        next_in = next_in + 8'd1;
      end else begin
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        checks++; if (b_out_data !== next_out) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, b_out_data, next_out); end
        next_out = next_out + 8'd1;
      end
      tick();
      checks++; if (b_count !== 2'(cnts[i])) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, b_count, cnts[i]); end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b want 0", b_out_valid); end
  endtask

  task automatic test_async_reset;
    a_in_valid = 1'b1; a_in_data = 8'h66;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL areset_pre got %0d want 2", a_count); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL areset_count got %0d want 0", a_count); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL areset_data got %h want 00", a_out_data); end
    checks++; if (a_flush_cnt !== 16'd0) begin errors++; $display("FAIL areset_flush_cnt got %0d want 0", a_flush_cnt); end
    tick();
    tick();
    checks++; if (a_flush_cnt !== 16'd0) begin errors++; $display("FAIL areset_hold_cnt got %0d want 0", a_flush_cnt); end
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'h77;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 8'h77) begin errors++; $display("FAIL first_push got %h want 77", a_out_data); end
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL first_push_count got %0d want 1", a_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the payload carried through the stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 2, number of payload entries held; SHALL be >= 1.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of count_o; SHALL NOT be overridden.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush_i  input  1  synchronous discard of all held entries.
REQ-007 in_valid_i  input  1  upstream offers in_data_i this cycle.
REQ-008 in_ready_o  output  1  stage can accept an entry this cycle.
REQ-009 in_data_i  input  WIDTH  upstream payload.
REQ-010 out_valid_o  output  1  out_data_o holds a valid entry.
REQ-011 out_ready_i  input  1  downstream consumes the head entry this cycle.
REQ-012 out_data_o  output  WIDTH  head-entry payload.
REQ-013 count_o  output  CW  number of entries currently held, 0..DEPTH.
REQ-014 flush_cnt_o  output  16  saturating count of entries discarded by flush.

Function
REQ-015 Push: in_valid_i & in_ready_o & !flush_i SHALL write in_data_i at the tail and advance the tail pointer.
REQ-016 Pop: out_valid_o & out_ready_i SHALL advance the head pointer; the pop completes even in a flush cycle.
REQ-017 Ordering: entries SHALL leave in strict FIFO order, with no loss or duplication.
REQ-018 in_ready_o SHALL equal (count_o != DEPTH); it SHALL NOT depend combinationally on out_ready_i or in_valid_i.
REQ-019 out_valid_o SHALL equal (count_o != 0).
REQ-020 out_data_o SHALL show the head entry when out_valid_o=1 and SHALL be all-zero when out_valid_o=0.
REQ-021 Latency: an entry pushed in cycle N on an empty stage SHALL appear with out_valid_o=1 in cycle N+1; there is no same-cycle pass-through.
REQ-022 Push and pop in the same cycle (count between 1 and DEPTH-1) SHALL leave count_o unchanged and keep both pointers consistent.
REQ-023 When full, a pop SHALL raise in_ready_o in the following cycle only; an offer in the full cycle is not accepted.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
REQ-025 count_o SHALL change by +1 on push only, by -1 on pop only, and SHALL otherwise be unchanged.
REQ-026 Flush: in the cycle after flush_i=1, count_o=0 and out_valid_o=0; head and tail pointers SHALL both be 0.
REQ-027 Flush and push in the same cycle: the push SHALL be dropped and SHALL NOT be counted as discarded.
REQ-028 flush_cnt_o SHALL increase by the number of entries discarded, i.e. count_o minus 1 if a pop also occurs in that cycle, else count_o.
REQ-029 flush_cnt_o SHALL saturate at 16'hFFFF.
REQ-030 DEPTH=1 SHALL behave as a half-throughput register: in_ready_o=0 whenever an entry is held.
REQ-031 Storage contents SHALL NOT be cleared by flush; only pointers and count SHALL be affected.

Reset
REQ-032 While rst=0, independent of clk: count_o=0, out_valid_o=0, in_ready_o=1, out_data_o=0, flush_cnt_o=0, pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries without incrementing flush_cnt_o.
REQ-034 Deassertion of rst SHALL be taken as synchronous to clk; the first push is accepted on the first rising edge with rst=1.

Verification (WIDTH=8, DEPTH=2 unless stated)
REQ-035 Push 8'hA1 into an empty stage with out_ready_i=0 -> next cycle out_valid_o=1, out_data_o=8'hA1, count_o=1.
REQ-036 Push A1, B2, C3 back-to-back with out_ready_i=0 -> count_o=2, in_ready_o=0, C3 not accepted; then out_ready_i=1 -> outputs A1 then B2, followed by out_valid_o=0 and out_data_o=0.
REQ-037 Continuous in_valid_i=1 and out_ready_i=1 at count_o=1, streaming 0x01..0x10 -> one entry output per cycle, in order, with count_o constant at 1.
REQ-038 Hold 2 entries, then apply flush_i=1 with out_ready_i=1 and in_valid_i=1 -> head entry is popped, pushed data is dropped, and next cycle count_o=0 with flush_cnt_o=1.
REQ-039 DEPTH=3: 7 pushes and 7 pops, interleaved to force pointer wrap -> all data matches in order and count_o never exceeds 3.
REQ-040 Drive rst=0 asynchronously between clock edges while 2 entries are held -> outputs reach reset values immediately, and flush_cnt_o stays 0.
